ripple_monitor: RTL

Synchronous consumer of the 2-bit ripple counter output. It samples the asynchronous `{qn1,qn0}` value on the system clock and rejects transient codes produced while the ripple settles. It converts accepted code changes into forward step counts, then publishes a running total and a per-window step rate.

---
 rtl/ripple_monitor.sv | 75 +++++++
 1 files changed

// File: rtl/ripple_monitor.sv
// ripple_monitor: synchronises a 2-bit ripple counter, filters transient codes, and reports total steps and per-window rate
// Ports: clk/rstn (async active-low) clock and reset; cnt_in ripple code {qn1,qn0}; clr sync clear;
//        total running step count; rate/rate_vld last window count and update pulse; ovf/alias_err sticky flags
module ripple_monitor #(
  parameter int TW     = 16,
  parameter int RW     = 8,
  parameter int WINDOW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    cnt_in,
  input  logic          clr,
  output logic [TW-1:0] total,
  output logic [RW-1:0] rate,
  output logic          rate_vld,
  output logic          ovf,
  output logic          alias_err
);
  localparam int CW = $clog2(WINDOW);
  logic [1:0]    r_s1, r_s2, r_s3, r_acc;
  logic [CW-1:0] r_wcnt;
  logic [RW-1:0] r_win;
  logic          w_take, w_last;
  logic [1:0]    w_delta;
  logic [TW:0]   w_sum;
  logic [RW:0]   w_wsum;
  logic [RW-1:0] w_wsat;
  // the source decrements per step, so forward distance is acc - s2
  always_comb begin
    w_take  = (r_s2 == r_s3) && (r_s2 != r_acc);
    w_delta = w_take ? r_acc - r_s2 : 2'd0;
    w_sum   = {1'b0, total} + (TW+1)'(w_delta);
    w_wsum  = {1'b0, r_win} + (RW+1)'(w_delta);
    w_wsat  = w_wsum[RW] ? '1 : w_wsum[RW-1:0];
    w_last  = r_wcnt == CW'(WINDOW-1);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1      <= 2'b11;
      r_s2      <= 2'b11;
      r_s3      <= 2'b11;
      r_acc     <= 2'b11;
      total     <= '0;
      r_win     <= '0;
      r_wcnt    <= '0;
      rate      <= '0;
      rate_vld  <= 1'b0;
      ovf       <= 1'b0;
      alias_err <= 1'b0;
    end else begin
      r_s1 <= cnt_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      // acc tracks even during clr so no false step follows
      if (w_take) r_acc <= r_s2;
      if (clr) begin
        total     <= '0;
        r_win     <= '0;
        r_wcnt    <= '0;
        rate      <= '0;
        rate_vld  <= 1'b0;
        ovf       <= 1'b0;
        alias_err <= 1'b0;
      end else begin
        total     <= w_sum[TW-1:0];
        ovf       <= ovf | w_sum[TW];
        alias_err <= alias_err | (w_delta == 2'd3);
        r_wcnt    <= w_last ? '0 : r_wcnt + CW'(1);
        r_win     <= w_last ? '0 : w_wsat;
        if (w_last) rate <= w_wsat;
        rate_vld  <= w_last;
      end
    end
  end
endmodule
